// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder family.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef logic [GROUP_W-1:0] nibble_t;

  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_4_adder_if.sv
// Operand/result bundle for cla_4_adder; master drives operands, slave returns the registered result.
interface cla_4_adder_if #(parameter int WIDTH = 4);

  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             czero;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;

  modport master (
    output in_valid, in1, in2, czero,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, in1, in2, czero,
    output sum, cout, out_valid
  );

endinterface

// File: rtl/cla_4_adder_cla4_block.sv
// Combinational 4-bit lookahead slice: sum bits plus group generate/propagate.
module cla4_block
  import cla_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    G,
  output logic    P
);

  nibble_t w_g;
  nibble_t w_p;
  nibble_t w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is a flat sum of products so no bit waits on its neighbour.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ w_c;

  assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign P = &w_p;

endmodule

// File: rtl/cla_4_adder.sv
// Registered WIDTH-bit carry-lookahead adder built from 4-bit slices and a second-level group lookahead.
module cla_4_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  cla_4_adder_if.slave bus
);

  localparam int NG = group_count(WIDTH);

  if ((WIDTH <= 0) || ((WIDTH % GROUP_W) != 0)) begin : g_bad_width
    $error("cla_4_adder: WIDTH must be a positive multiple of 4");
  end

  // Carry into group k: OR over every source (czero or an earlier G) ANDed with all P above it.
  function automatic logic [NG:0] group_carry(input logic [NG-1:0] g,
                                              input logic [NG-1:0] p,
                                              input logic          c0);
    logic [NG:0] src;
    logic [NG:0] c;
    logic        term;
    src = {g, c0};
    c   = '0;
    for (int k = 0; k <= NG; k++) begin
      for (int j = 0; j <= k; j++) begin
        term = src[j];
        for (int m = j; m < k; m++) begin
          term = term & p[m];
        end
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gc;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  for (genvar gi = 0; gi < NG; gi++) begin : g_blk
    cla4_block u_blk (
      .a   (bus.in1[gi*GROUP_W +: GROUP_W]),
      .b   (bus.in2[gi*GROUP_W +: GROUP_W]),
      .cin (w_gc[gi]),
      .s   (w_sum[gi*GROUP_W +: GROUP_W]),
      .G   (w_gg[gi]),
      .P   (w_gp[gi])
    );
  end

  always_comb begin
    w_gc = group_carry(w_gg, w_gp, bus.czero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_gc[NG];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_cla_4_adder.sv
// Self-checking bench for cla_4_adder at WIDTH 4, 8 and 16 against a plain-arithmetic reference.
module tb_cla_4_adder;

  logic clk;
  logic rst_n;

  cla_4_adder_if #(.WIDTH(4))  if4 ();
  cla_4_adder_if #(.WIDTH(8))  if8 ();
  cla_4_adder_if #(.WIDTH(16)) if16 ();

  cla_4_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  cla_4_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  cla_4_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference state: what each output should hold
  logic [3:0]  m4_sum;
  logic        m4_cout, m4_ov;
  logic [7:0]  m8_sum;
  logic        m8_cout, m8_ov;
  logic [15:0] m16_sum;
  logic        m16_cout, m16_ov;

  typedef struct {
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] es;
    logic       ec;
    logic       eov;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m4_sum = '0;  m4_cout = 1'b0;  m4_ov = 1'b0;
    m8_sum = '0;  m8_cout = 1'b0;  m8_ov = 1'b0;
    m16_sum = '0; m16_cout = 1'b0; m16_ov = 1'b0;
  endtask

  // Drive a 4-bit operand set, let one edge sample it, then settle past the edge.
  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    if4.in_valid = v; if4.in1 = a; if4.in2 = b; if4.czero = c;
    @(posedge clk);
    if (rst_n) begin
      r = 5'(a) + 5'(b) + 5'(c);
      if (v) begin
        m4_sum  = r[3:0];
        m4_cout = r[4];
      end
      m4_ov = v;
    end
    #1;
  endtask

  task automatic check4(input string tag);
    chk({tag, "_sum"},  32'(if4.sum),       32'(m4_sum));
    chk({tag, "_cout"}, 32'(if4.cout),      32'(m4_cout));
    chk({tag, "_ov"},   32'(if4.out_valid), 32'(m4_ov));
  endtask

  task automatic drive_wide(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r16;
    logic [8:0]  r8;
    if8.in_valid  = v; if8.in1  = a[7:0]; if8.in2  = b[15:8]; if8.czero  = c;
    if16.in_valid = v; if16.in1 = a;      if16.in2 = b;       if16.czero = c;
    @(posedge clk);
    r16 = 17'(a) + 17'(b) + 17'(c);
    r8  = 9'(a[7:0]) + 9'(b[15:8]) + 9'(c);
    if (v) begin
      m16_sum = r16[15:0]; m16_cout = r16[16];
      m8_sum  = r8[7:0];   m8_cout  = r8[8];
    end
    m16_ov = v;
    m8_ov  = v;
    #1;
    chk("w16_sum",  32'(if16.sum),       32'(m16_sum));
    chk("w16_cout", 32'(if16.cout),      32'(m16_cout));
    chk("w16_ov",   32'(if16.out_valid), 32'(m16_ov));
    chk("w8_sum",   32'(if8.sum),        32'(m8_sum));
    chk("w8_cout",  32'(if8.cout),       32'(m8_cout));
    chk("w8_ov",    32'(if8.out_valid),  32'(m8_ov));
  endtask

  initial begin
    logic [15:0] corners[4];
    logic [8:0]  idx;

    tbl[0] = '{1'b1, 4'd1,  4'd2,  1'b0, 4'd3,  1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'd7,  4'd8,  1'b1, 4'd0,  1'b1, 1'b1};
    tbl[2] = '{1'b1, 4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b1};
    tbl[3] = '{1'b1, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 4'd1,  4'd2,  1'b0, 4'd3,  1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'd5,  4'd5,  1'b0, 4'd3,  1'b0, 1'b0};
    tbl[7] = '{1'b0, 4'd9,  4'd9,  1'b1, 4'd3,  1'b0, 1'b0};
    tbl[8] = '{1'b1, 4'd10, 4'd5,  1'b0, 4'd15, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};

    corners[0] = 16'h0000;
    corners[1] = 16'hFFFF;
    corners[2] = 16'hAAAA;
    corners[3] = 16'h5555;

    model_reset();
    if8.in_valid = 1'b0;  if8.in1 = '0;  if8.in2 = '0;  if8.czero = 1'b0;
    if16.in_valid = 1'b0; if16.in1 = '0; if16.in2 = '0; if16.czero = 1'b0;

    // Reset held with valid operands present: outputs stay at reset values.
    rst_n = 1'b0;
    drive4(1'b1, 4'd9, 4'd9, 1'b1);
    drive4(1'b1, 4'd9, 4'd9, 1'b1);
    check4("reset");
    rst_n = 1'b1;
    drive4(1'b1, 4'd1, 4'd2, 1'b0);
    check4("post_release");

    for (int i = 0; i < 10; i++) begin
      drive4(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c);
      chk($sformatf("tbl%0d_sum", i),  32'(if4.sum),       32'(tbl[i].es));
      chk($sformatf("tbl%0d_cout", i), 32'(if4.cout),      32'(tbl[i].ec));
      chk($sformatf("tbl%0d_ov", i),   32'(if4.out_valid), 32'(tbl[i].eov));
    end

    // Asynchronous reset between edges clears outputs without a clock.
    drive4(1'b1, 4'd15, 4'd15, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check4("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive4(1'b0, 4'd3, 4'd4, 1'b0);
    check4("after_rst_idle");
    drive4(1'b1, 4'd3, 4'd4, 1'b0);
    check4("after_rst_first");

    // Exhaustive, back-to-back, one operand set per cycle.
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      drive4(1'b1, idx[3:0], idx[7:4], idx[8]);
      check4("exh");
    end
    drive4(1'b0, 4'd0, 4'd0, 1'b0);
    if4.in_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        drive_wide(1'b1, corners[i], corners[j], 1'b0);
        drive_wide(1'b1, corners[i], corners[j], 1'b1);
      end
    end
    for (int i = 0; i < 400; i++) begin
      drive_wide(($urandom_range(0, 7) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_4_adder.md
# cla_4_adder

Registered 4-bit carry-lookahead adder, extendable to multiples of 4 bits through a second-level group lookahead. It adds two unsigned operands and a carry-in, and presents sum and carry-out one clock after the inputs are sampled. It is the fast-adder leaf used in the final carry-propagate stage of the approximate Dadda multiplier datapath, alongside the modified full-adder (mfa) compressors.

## Interface
- WIDTH, default 4; operand and sum width; must be a positive multiple of 4 (elaboration error otherwise).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in1/in2/czero this cycle.
- in1  input  WIDTH  unsigned operand A.
- in2  input  WIDTH  unsigned operand B.
- czero  input  1  carry-in (c0).
- sum  output  WIDTH  registered (in1 + in2 + czero) mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of the full result.
- out_valid  output  1  registered copy of in_valid.

## Operation
- Per bit i: g[i] = in1[i] & in2[i]; p[i] = in1[i] ^ in2[i].
- Within each 4-bit group, carries come from lookahead equations, not a ripple chain: c1 = g0 | p0·c0; c2 = g1 | p1·g0 | p1·p0·c0; c3 and c4 follow the same expansion.
- sum[i] = p[i] ^ c[i].
- Group generate G = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0; group propagate P = p3·p2·p1·p0.
- For WIDTH > 4, the group carry-in of group k comes from second-level lookahead over (G, P) of groups 0..k-1 and czero. cout is the carry out of the top group.
- Arithmetic identity: {cout, sum} == in1 + in2 + czero for every input combination.
- When in_valid = 1 on a rising edge, sum/cout load the new result and out_valid is set to 1.
- When in_valid = 0 on a rising edge, sum/cout hold their previous values and out_valid is cleared to 0.
- No back-pressure. A new operand set may be accepted every cycle.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on sum/cout/out_valid after edge N.
- Throughput: 1 result per cycle.
- Reset values: sum = 0, cout = 0, out_valid = 0. Reset is applied asynchronously on rst_n falling. Release is synchronous to the next clk edge.
- Reset asserted mid-stream: any in-flight result is discarded. The first valid output after release corresponds to the first in_valid sampled after release.
- Inputs must be stable for setup/hold around the rising edge. The combinational path is purely lookahead, so depth is logarithmic in the group count.

## Structure
- Shared package cla_pkg holds:
  - localparam GROUP_W = 4.
  - Helper function group_count(WIDTH) = WIDTH / GROUP_W.
- Sub-module cla4_block: combinational 4-bit lookahead slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], G, P.
- Top level contains:
  - A generate loop of cla4_block instances.
  - The second-level group-carry lookahead.
  - The output register stage with asynchronous reset.
- For WIDTH = 4, the top level reduces to one block; cout = G | P·czero.

## Test plan
- Reset: hold rst_n = 0 with clk running and in_valid = 1 -> sum = 0, cout = 0, out_valid = 0. After release, the first result appears one cycle after the first sampled in_valid.
- Basic add: in1 = 1, in2 = 2, czero = 0, in_valid = 1 -> next cycle sum = 3, cout = 0, out_valid = 1.
- Full propagate chain: in1 = 7, in2 = 8, czero = 1 -> sum = 0, cout = 1. Then in1 = 15, in2 = 0, czero = 1 -> sum = 0, cout = 1.
- Maximum operands: in1 = 15, in2 = 15, czero = 1 -> sum = 15, cout = 1. With czero = 0 -> sum = 14, cout = 1.
- Hold behaviour: drive in_valid = 0 with in1 = 5, in2 = 5 after a result of 3 -> sum stays 3, cout stays 0, out_valid = 0.
- Exhaustive plus pipelined checks:
  - All 512 (in1, in2, czero) combinations back-to-back, one per cycle; each output is compared to a reference sum one cycle later.
  - Repeat for WIDTH = 8 and WIDTH = 16 with random vectors plus the corner values 0, all-ones and alternating bits.
